serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder that processes one operand bit per clock through a single full-adder cell and a registered carry. It sits directly upstream of result consumers that accept a parallel word plus carry, and replaces a WIDTH-cell parallel ripple chain where area matters more than latency. Operands load in parallel, are consumed LSB-first, and the result is presented in parallel with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/result width in bits (legal range 2..32)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- sub  input  1  subtract select (present only with SERIAL_ADDER_SUB_EN)
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: sum/cout/ovf valid
- sum  output  WIDTH  result word, held until next completion
- cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  two's-complement overflow (carry into MSB XOR cout)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 → load a_sr←a, b_sr←b, carry←cin (subtract: carry←1, b_sr←~b), bit counter←0, go SHIFT. start=0 → stay.
- SHIFT, each cycle: s = a_sr[0]^b_sr[0]^carry; c = majority(a_sr[0], b_sr[0], carry). s shifted into MSB of internal sum_sr (sum_sr shifts right); a_sr, b_sr shift right; carry←c; counter increments.
- On the cycle processing bit WIDTH-2, the current carry is saved as c_msb_in for ovf.
- After bit WIDTH-1 is processed: result registers sum←final sum_sr, cout←c, ovf←c_msb_in^c; go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start in SHIFT or DONE is ignored (not queued); a/b/cin/sub changes after acceptance have no effect.
- Counter width is clog2(WIDTH); wraps are never reached because SHIFT exits at WIDTH-1.
- Internal sum_sr is never visible; sum/cout/ovf change only on the SHIFT→DONE transition.

## Timing
- Reset (rst_n=0 at a rising edge): state←IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, all internal registers 0. Applies mid-operation: the operation is aborted, no done pulse.
- Start accepted at edge E0 → busy=1 from after E0 through edge E_WIDTH; bits consumed on edges E1..E_WIDTH.
- After E_WIDTH: busy=0, done=1, results valid. After E_WIDTH+1: done=0, state IDLE, results held.
- Earliest next accepted start: edge E_WIDTH+2. Throughput one operation per WIDTH+2 cycles.
- busy and done are registered outputs, never high together.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub port exists; sub=1 captured on start computes a − b (b inverted, carry forced to 1, cin ignored); cout=1 means a ≥ b unsigned; ovf is signed overflow of the subtraction. sub=0 behaves as addition.
- Not defined: no sub port, addition only (a + b + cin); no inversion logic.

## Test plan
- Add WIDTH=8, a=0x5A, b=0x3C, cin=0 → after 9 cycles done pulse, sum=0x96, cout=0, ovf=1; busy high exactly 8 cycles.
- Add a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0; a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- With SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 → sum=0x0F, cout=1, ovf=0; a=0x00, b=0x01, sub=1 → sum=0xFF, cout=0; a=0x80, b=0x01 → sum=0x7F, ovf=1.
- Start pulsed while busy with different operands → ignored; original result returned, single done pulse; outputs stable until next completion.
- rst_n=0 at cycle 4 of an operation → busy=0, done never asserted, sum/cout/ovf=0; new start after reset completes correctly.
- Back-to-back: start held high continuously → operations accepted every 10 cycles (WIDTH=8), each with one done pulse and correct results.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell with a registered carry, LSB-first.
// Define SERIAL_ADDER_SUB_EN to add the sub port and a - b support.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit  = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] MsbInBit = CntW'(WIDTH - 2);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds the WIDTH-1 low result bits; the MSB comes straight from the adder cell.
  logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_msb_in_q, c_msb_in_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  assign sum_shift = {bit_s, sum_sr_q};

`ifdef SERIAL_ADDER_SUB_EN
  // a - b = a + ~b + 1; cin is ignored when subtracting.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    sum_sr_d   = sum_sr_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    c_msb_in_d = c_msb_in_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift[WIDTH-1:1];
        carry_d  = bit_c;
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == MsbInBit) begin
          c_msb_in_d = bit_c;
        end
        if (cnt_q == LastBit) begin
          sum_d   = sum_shift;
          cout_d  = bit_c;
          ovf_d   = c_msb_in_q ^ bit_c;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StShift);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      sum_sr_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      c_msb_in_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      sum_sr_q   <= sum_sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      c_msb_in_q <= c_msb_in_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  busy_done_exclusive: assert property (@(posedge clk) !(busy_q && done_q));

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
// Subtract scenarios are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned/signed integer arithmetic.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    res_t   r;
    longint sx, sy, full, ux, uy, ufull;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    if (sb) begin
      ufull  = ux - uy;
      r.cout = (ux >= uy);
      full   = sx - sy;
    end else begin
      ufull  = ux + uy + longint'(ci);
      r.cout = (ufull >= (longint'(1) << W));
      full   = sx + sy + longint'(ci);
    end
    r.sum = ufull[W-1:0];
    r.ovf = (full > ((longint'(1) << (W - 1)) - 1)) || (full < -(longint'(1) << (W - 1)));
    return r;
  endfunction

  // Launches one operation from idle; returns at the sample where done is seen.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input logic sv, output res_t got, output int busy_cnt, output int lat);
    a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0;
    lat = 0;
    while (!done && lat <= 4 * W) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    got = {sum, cout, ovf};
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_timeout: no done after %0d cycles, required within %0d", lat, W);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic run_vector(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv, input res_t exp);
    res_t got;
    int   bc, lat;
    do_op(av, bv, cv, sv, got, bc, lat);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               name, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
    end
    checks++;
    if (bc !== W || lat !== W) begin
      errors++;
      $display("FAIL %s_timing: busy_cycles=%0d done_latency=%0d, required %0d %0d",
               name, bc, lat, W, W);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {sum, cout, ovf} !== exp) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b sum=%h, required 0 0 %h",
               name, done, busy, sum, exp.sum);
    end
  endtask

  task automatic test_add_directed();
    run_vector("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, '{sum: 8'h96, cout: 1'b0, ovf: 1'b1});
    run_vector("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
    run_vector("add_cin", 8'h00, 8'h00, 1'b1, 1'b0, '{sum: 8'h01, cout: 1'b0, ovf: 1'b0});
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub_directed();
    // cin deliberately 1 on the first case: it must be ignored when subtracting.
    run_vector("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b1, '{sum: 8'h0F, cout: 1'b1, ovf: 1'b0});
    run_vector("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, '{sum: 8'hFF, cout: 1'b0, ovf: 1'b0});
    run_vector("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1});
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] av, bv;
    logic         cv, sv;
    for (int i = 0; i < 20; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      cv = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sv = 1'($urandom);
`else
      sv = 1'b0;
`endif
      run_vector("random", av, bv, cv, sv, model(av, bv, cv, sv));
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] sum_prev;
    res_t         got, exp;
    int           dones = 0, done_at = 0;
    bit           stable_ok = 1'b1;
    sum_prev = sum;
    exp = model(8'h33, 8'h44, 1'b0, 1'b0);
    a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = '0;
    for (int k = 1; k <= W + 6; k++) begin
      if (k >= 3 && k <= 5) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        dones++;
        done_at = k;
        got = {sum, cout, ovf};
      end else if (done_at == 0 && sum !== sum_prev) begin
        stable_ok = 1'b0;
      end else if (done_at != 0 && sum !== got.sum) begin
        stable_ok = 1'b0;
      end
    end
    start = 1'b0; sub = 1'b0;
    checks++;
    if (dones !== 1 || done_at !== W) begin
      errors++;
      $display("FAIL ignore_done_pulse: pulses=%0d at=%0d, required 1 at %0d", dones, done_at, W);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ignore_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL ignore_sum_stable: sum=%h changed outside completion, required held",
               sum);
    end
  endtask

  task automatic test_mid_reset();
    int           done_seen = 0;
    logic [W-1:0] av, bv;
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2 * W; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: pulses=%0d, required 0", done_seen);
    end
    av = W'($urandom);
    bv = W'($urandom);
    run_vector("after_reset", av, bv, 1'b1, 1'b0, model(av, bv, 1'b1, 1'b0));
  endtask

  task automatic test_back_to_back();
    localparam int N = 4;
    res_t q[$];
    res_t exp, got;
    int   issued = 0, seen = 0, last_done = -1, cyc = 0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0;
    q.push_back(model(a, b, cin, 1'b0));
    issued++;
    start = 1'b1;
    while (seen < N && cyc < N * (W + 2) + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        exp = q.pop_front();
        got = {sum, cout, ovf};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL b2b_result_%0d: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   seen, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done !== W + 2) begin
            errors++;
            $display("FAIL b2b_interval_%0d: %0d cycles, required %0d",
                     seen, cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
        seen++;
        if (issued < N) begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
          q.push_back(model(a, b, cin, 1'b0));
          issued++;
        end else begin
          start = 1'b0;
        end
      end else if (busy) begin
        // Operands may change freely once captured.
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    start = 1'b0;
    if (seen < N) begin
      checks++; errors++;
      $display("FAIL b2b_timeout: completed %0d ops, required %0d", seen, N);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add_directed();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub_directed();
`endif
    test_random();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
